// File: rtl/clock_setter.sv
// Front-panel setting controller: conditions three raw buttons and runs the
// hour/min/sec/day/month/year edit FSM that loads the clock/calendar counter.
module clock_setter #(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int BLINK_CYCLES    = 12_500_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        butt_change,
   input  logic        butt_increase,
   input  logic        butt_decrease,
   input  logic [23:0] cur_time,
   input  logic [31:0] cur_date,
   output logic        edit_active,
   output logic [2:0]  edit_field,
   output logic [23:0] set_time,
   output logic [31:0] set_date,
   output logic        set_strobe,
   output logic        blink_on
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int BW = $clog2(BLINK_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HOUR  = 3'd1,
      S_MIN   = 3'd2,
      S_SEC   = 3'd3,
      S_DAY   = 3'd4,
      S_MONTH = 3'd5,
      S_YEAR  = 3'd6
   } state_t;

   // Two-digit BCD step with wrap; an out-of-range value snaps to the minimum.
   function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up,
                                           input logic [7:0] lo, input logic [7:0] hi);
      logic [7:0] r;
      if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v < lo || v > hi) r = lo;
      else if (up) begin
         if (v == hi)              r = lo;
         else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
         else                      r = v + 8'd1;
      end else begin
         if (v == lo)              r = hi;
         else if (v[3:0] == 4'd0)  r = {v[7:4] - 4'd1, 4'd9};
         else                      r = v - 8'd1;
      end
      return r;
   endfunction

   function automatic logic [15:0] year_step(input logic [15:0] y, input logic up);
      logic [15:0] r;
      logic        carry;
      logic        bad;
      r     = y;
      carry = 1'b1;
      bad   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (y[4*i +: 4] > 4'd9) bad = 1'b1;
         if (carry) begin
            if (up) begin
               if (y[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
               else begin r[4*i +: 4] = y[4*i +: 4] + 4'd1; carry = 1'b0; end
            end else begin
               if (y[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
               else begin r[4*i +: 4] = y[4*i +: 4] - 4'd1; carry = 1'b0; end
            end
         end
      end
      return bad ? 16'h0000 : r;
   endfunction

   // BCD tens*10+ones is divisible by 4 iff (2*tens + ones) is.
   function automatic logic div4(input logic [7:0] b);
      if (b[4]) return (b[3:0] == 4'd2) || (b[3:0] == 4'd6);
      return (b[3:0] == 4'd0) || (b[3:0] == 4'd4) || (b[3:0] == 4'd8);
   endfunction

   function automatic logic [7:0] day_max(input logic [7:0] mon, input logic [15:0] yr);
      logic       leap;
      logic [7:0] r;
      leap = (yr[7:0] != 8'h00) ? div4(yr[7:0]) : div4(yr[15:8]);
      case (mon)
         8'h02:                      r = leap ? 8'h29 : 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
         default:                    r = 8'h31;
      endcase
      return r;
   endfunction

   logic [2:0]    raw;
   logic [2:0]    sync1_q, sync2_q, deb_q, deb_dly_q, press_q;
   logic [DW-1:0] deb_cnt_q [3];

   assign raw = {butt_decrease, butt_increase, butt_change};

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= 3'b111;
         sync2_q   <= 3'b111;
         deb_q     <= 3'b111;
         deb_dly_q <= 3'b111;
         press_q   <= 3'b000;
         for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
      end else begin
         sync1_q   <= raw;
         sync2_q   <= sync1_q;
         deb_dly_q <= deb_q;
         press_q   <= deb_dly_q & ~deb_q;
         for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == deb_q[i]) deb_cnt_q[i] <= '0;
            else if (deb_cnt_q[i] == DEB_LAST) begin
               deb_q[i]     <= sync2_q[i];
               deb_cnt_q[i] <= '0;
            end else deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
         end
      end
   end

   state_t        state_q;
   logic [23:0]   time_q, time_d;
   logic [31:0]   date_q, date_d;
   logic [7:0]    month_n, dmax;
   logic [15:0]   year_n;
   logic          strobe_q, blink_q;
   logic [BW-1:0] blink_cnt_q;
   logic          chg, up, step;

   assign chg  = press_q[0];
   assign up   = press_q[1];
   assign step = press_q[1] ^ press_q[2];

   always_comb begin
      time_d  = time_q;
      date_d  = date_q;
      month_n = date_q[23:16];
      year_n  = date_q[15:0];
      case (state_q)
         S_HOUR:  time_d[23:16] = bcd_step(time_q[23:16], up, 8'h00, 8'h23);
         S_MIN:   time_d[15:8]  = bcd_step(time_q[15:8],  up, 8'h00, 8'h59);
         S_SEC:   time_d[7:0]   = bcd_step(time_q[7:0],   up, 8'h00, 8'h59);
         S_DAY:   date_d[31:24] = bcd_step(date_q[31:24], up, 8'h01,
                                           day_max(date_q[23:16], date_q[15:0]));
         S_MONTH: month_n = bcd_step(date_q[23:16], up, 8'h01, 8'h12);
         S_YEAR:  year_n  = year_step(date_q[15:0], up);
         default: ;
      endcase
      dmax = day_max(month_n, year_n);
      // Month/year edits pull the day back into the new month's range.
      if (state_q == S_MONTH || state_q == S_YEAR)
         date_d = {(date_q[31:24] > dmax) ? dmax : date_q[31:24], month_n, year_n};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         strobe_q    <= 1'b0;
         time_q      <= 24'h000000;
         date_q      <= 32'h0101_2024;
         blink_q     <= 1'b1;
         blink_cnt_q <= '0;
      end else begin
         strobe_q <= 1'b0;
         if (chg) begin
            blink_q     <= 1'b1;
            blink_cnt_q <= '0;
            case (state_q)
               S_IDLE: begin
                  state_q <= S_HOUR;
                  time_q  <= cur_time;
                  date_q  <= cur_date;
               end
               S_YEAR: begin
                  state_q  <= S_IDLE;
                  strobe_q <= 1'b1;
               end
               default: state_q <= state_t'(state_q + 3'd1);
            endcase
         end else begin
            if (state_q == S_IDLE) begin
               blink_q     <= 1'b1;
               blink_cnt_q <= '0;
            end else begin
               if (blink_cnt_q == BLINK_LAST) begin
                  blink_cnt_q <= '0;
                  blink_q     <= ~blink_q;
               end else blink_cnt_q <= blink_cnt_q + BW'(1);
               if (step) begin
                  time_q <= time_d;
                  date_q <= date_d;
               end
            end
         end
      end
   end

   assign edit_field  = state_q;
   assign edit_active = (state_q != S_IDLE);
   assign set_time    = time_q;
   assign set_date    = date_q;
   assign set_strobe  = strobe_q;
   assign blink_on    = blink_q;

endmodule
